fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_if.sv | 51 +++++
 rtl/fetch_unit.sv | 113 +++++++++++
 tb/tb_fetch_unit.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_if
// Description : Fetch-stage signal bundle. It carries the decode
//               handshake, the execute redirect and the synchronous
//               instruction-memory port. The master modport is the fetch
//               unit's view and the slave modport is the environment's view.
// Revision    : 1.0  initial release
// ============================================================================
interface fetch_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        decode_valid;
    logic [31:0] decode_inst;
    logic [31:0] decode_pc;
    logic        misalign_err;
    logic [31:0] fetch_count;

    modport master (
        input  stall,
        input  redirect,
        input  redirect_pc,
        input  imem_rdata,
        output imem_en,
        output imem_addr,
        output decode_valid,
        output decode_inst,
        output decode_pc,
        output misalign_err,
        output fetch_count
    );

    modport slave (
        output stall,
        output redirect,
        output redirect_pc,
        output imem_rdata,
        input  imem_en,
        input  imem_addr,
        input  decode_valid,
        input  decode_inst,
        input  decode_pc,
        input  misalign_err,
        input  fetch_count
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Single-issue instruction fetch stage. It issues one read per
//               cycle to a synchronous instruction memory with one cycle of
//               latency. A one-entry hold buffer keeps the presented
//               instruction stable while decode stalls. A redirect takes
//               priority over a stall and costs one cycle. A misaligned
//               redirect target sets a sticky error bit.
// Revision    : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
    input  wire logic clk,
    input  wire logic rst,
    fetch_if.master   bus
);

    logic [31:0] r_fetch_pc;
    logic        r_req_pending;
    logic [31:0] r_req_pc;
    logic        r_hold_valid;
    logic [31:0] r_hold_inst;
    logic [31:0] r_hold_pc;
    logic        r_misalign_err;
    logic [31:0] r_fetch_count;

    logic        w_imem_en;
    logic [31:0] w_imem_addr;
    logic        w_decode_valid;
    logic        w_accept;
    logic        w_capture;

    // A redirect always reads its word-aligned target, even under stall.
    // Otherwise a new read is issued only when decode is free to move on.
    assign w_imem_en   = !rst && (bus.redirect || !bus.stall);
    assign w_imem_addr = bus.redirect ? {bus.redirect_pc[31:2], 2'b00} : r_fetch_pc;

    // An instruction is live if it is held or if a read returns this cycle.
    // The reset term keeps decode_valid low while rst is high, before the
    // registers have been cleared.
    assign w_decode_valid = !rst && (r_hold_valid || r_req_pending);
    assign w_accept       = w_decode_valid && !bus.stall;

    // Memory data lasts only one cycle, so a stalled live response is
    // copied into the hold buffer. A redirect makes that response
    // wrong-path, so it is not captured.
    assign w_capture = r_req_pending && bus.stall && !r_hold_valid && !bus.redirect;

    assign bus.imem_en      = w_imem_en;
    assign bus.imem_addr    = w_imem_addr;
    assign bus.decode_valid = w_decode_valid;
    assign bus.decode_inst  = r_hold_valid ? r_hold_inst : bus.imem_rdata;
    assign bus.decode_pc    = r_hold_valid ? r_hold_pc   : r_req_pc;
    assign bus.misalign_err = !rst && r_misalign_err;
    assign bus.fetch_count  = rst ? 32'd0 : r_fetch_count;

    // Fetch PC and outstanding-read tracking. The PC advances past every
    // issued read and wraps modulo 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_req_pending <= 1'b0;
            r_req_pc      <= RESET_PC;
        end else begin
            if (w_imem_en) begin
                r_fetch_pc <= w_imem_addr + 32'd4;
            end
            r_req_pending <= w_imem_en;
            r_req_pc      <= w_imem_addr;
        end
    end

    // Hold-buffer valid flag. A redirect or an accept empties the buffer;
    // a stalled live response fills it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_valid <= 1'b0;
        end else if (bus.redirect || w_accept) begin
            r_hold_valid <= 1'b0;
        end else if (w_capture) begin
            r_hold_valid <= 1'b1;
        end
    end

    // Hold-buffer payload. It only has meaning while r_hold_valid is set,
    // so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_hold_inst <= bus.imem_rdata;
            r_hold_pc   <= r_req_pc;
        end
    end

    // Sticky misalignment flag and the accepted-instruction counter.
    // An accept in a redirect cycle is wrong-path and is not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign_err <= 1'b0;
            r_fetch_count  <= 32'd0;
        end else begin
            if (bus.redirect && (bus.redirect_pc[1:0] != 2'b00)) begin
                r_misalign_err <= 1'b1;
            end
            if (w_accept && !bus.redirect) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. A stream-level model
//               predicts which instruction decode sees in each cycle. That
//               model is driven through directed scenarios and then through
//               random stall, redirect and reset traffic.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] C_RESET_PC = 32'h4000_0000;

    logic clk;
    logic rst;
    fetch_if bus ();

    fetch_unit #(.RESET_PC(C_RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Stream-level reference model state
    logic        m_valid;  // decode is presented a live instruction
    logic [31:0] m_pc;     // pc of that instruction
    logic [31:0] m_next;   // address of the next sequential fetch
    logic [31:0] m_count;
    logic        m_err;

    // Memory contents: the word at RESET_PC + 4*i holds i
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - C_RESET_PC;
        return {2'b00, off[31:2]};
    endfunction

    // Synchronous memory: data is valid only in the cycle after the read.
    // Every other cycle returns garbage.
    always @(posedge clk) begin
        if (bus.imem_en) bus.imem_rdata <= mem_word(bus.imem_addr);
        else             bus.imem_rdata <= $urandom;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle with rst asserted. The outputs must be quiet no matter
    // what the other inputs do.
    task automatic reset_cycle(input logic s);
        @(negedge clk);
        rst             = 1'b1;
        bus.stall       = s;
        bus.redirect    = 1'($urandom_range(0, 1));
        bus.redirect_pc = $urandom;
        #1;
        check("rst_imem_en",      {31'd0, bus.imem_en},      32'd0);
        check("rst_decode_valid", {31'd0, bus.decode_valid}, 32'd0);
        check("rst_misalign_err", {31'd0, bus.misalign_err}, 32'd0);
        check("rst_fetch_count",  bus.fetch_count,           32'd0);
        m_valid = 1'b0;
        m_next  = C_RESET_PC;
        m_count = 32'd0;
        m_err   = 1'b0;
    endtask

    // One normal cycle: apply inputs, compare against the model, then
    // advance the model by the effect of this cycle's clock edge.
    task automatic step(input logic s, input logic r, input logic [31:0] rp);
        logic [31:0] exp_addr;
        @(negedge clk);
        rst             = 1'b0;
        bus.stall       = s;
        bus.redirect    = r;
        bus.redirect_pc = rp;
        #1;
        exp_addr = r ? {rp[31:2], 2'b00} : m_next;
        check("imem_en",      {31'd0, bus.imem_en},      {31'd0, (r || !s)});
        check("imem_addr",    bus.imem_addr,             exp_addr);
        check("decode_valid", {31'd0, bus.decode_valid}, {31'd0, m_valid});
        if (m_valid) begin
            check("decode_pc",   bus.decode_pc,   m_pc);
            check("decode_inst", bus.decode_inst, mem_word(m_pc));
        end
        check("fetch_count",  bus.fetch_count,           m_count);
        check("misalign_err", {31'd0, bus.misalign_err}, {31'd0, m_err});

        if (r) begin
            // Wrong-path instruction is dropped; the target shows next cycle
            if (rp[1:0] != 2'b00) m_err = 1'b1;
            m_valid = 1'b1;
            m_pc    = {rp[31:2], 2'b00};
            m_next  = m_pc + 32'd4;
        end else if (m_valid && !s) begin
            m_count = m_count + 32'd1;
            m_pc    = m_next;
            m_next  = m_next + 32'd4;
        end else if (!m_valid && !s) begin
            m_valid = 1'b1;
            m_pc    = m_next;
            m_next  = m_next + 32'd4;
        end
        // Stalled with no redirect: everything stays the same
    endtask

    initial begin
        rst             = 1'b1;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'd0;
        m_valid = 1'b0;
        m_pc    = C_RESET_PC;
        m_next  = C_RESET_PC;
        m_count = 32'd0;
        m_err   = 1'b0;

        // Reset release and a sequential stream, one instruction per cycle
        reset_cycle(1'b0);
        reset_cycle(1'b0);
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);

        // Stall for 3 cycles while 4000_0008 is presented
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);

        // Redirect to 4000_0100
        step(1'b0, 1'b1, 32'h4000_0100);
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);

        // Redirect under stall while the hold buffer is full
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'h4000_0200);
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);

        // Misaligned redirect: the error is sticky and only reset clears it
        step(1'b0, 1'b1, 32'h4000_0102);
        step(1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        reset_cycle(1'b0);
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);

        // Reset in the second cycle of a stall, then restart from RESET_PC
        step(1'b1, 1'b0, 32'd0);
        reset_cycle(1'b1);
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);

        // Address wrap across 2^32
        step(1'b0, 1'b1, 32'hFFFF_FFF8);
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                reset_cycle(1'($urandom_range(0, 1)));
            end else begin
                step(($urandom_range(0, 99) < 35),
                     ($urandom_range(0, 99) < 12),
                     C_RESET_PC + 32'($urandom_range(0, 2047)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
